// File: rtl/rst_stretch_pkg.sv
// Shared types and constants for the reset concentrator/stretcher.
// Holds the FSM state encoding, the reset-cause encoding and the
// lower bounds on the block parameters.
package rst_stretch_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Encoding 2'd3 is reserved and never produced.
    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_EXT = 2'd1,
        CAUSE_SW  = 2'd2
    } cause_t;

    localparam int MIN_SYNC_STAGES    = 2;
    localparam int MIN_STRETCH_CYCLES = 2;

endpackage

// File: rtl/rst_req_sync.sv
// N-stage single-bit synchronizer with asynchronous active-high clear to 0.
module rst_req_sync #(
    parameter int STAGES = 3
) (
    input  logic clock,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_stretch_sync.sv
// Reset-request concentrator and stretcher.
// Merges power-on, an asynchronous external request and a software
// handshake into one synchronously-deasserted, minimum-width reset level.
// Optional feature: define RST_STRETCH_FILTER_EN to require the
// synchronized external request to be high for two consecutive cycles.
//
// state | meaning
// HOLD  | rst_out high, stretch counter running toward STRETCH_CYCLES-1
// RUN   | rst_out low, software requests accepted
module rst_stretch_sync
    import rst_stretch_pkg::*;
#(
    parameter int SYNC_STAGES    = 3,
    parameter int STRETCH_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_async,
    input  logic       sw_req_valid,
    output logic       sw_req_ready,
    output logic       rst_out,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam int                 CNT_W    = $clog2(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("rst_stretch_sync: SYNC_STAGES must be >= 2");
    end
    if (STRETCH_CYCLES < MIN_STRETCH_CYCLES) begin : g_bad_stretch
        $error("rst_stretch_sync: STRETCH_CYCLES must be >= 2");
    end

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    cause_t            cause, cause_nx;
    logic              req_s;
    logic              req_hit;

    rst_req_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clock (clock),
        .clear (reset),
        .d     (req_async),
        .q     (req_s)
    );

`ifdef RST_STRETCH_FILTER_EN
    logic req_s_d;

    // Delay the synchronized request one cycle so single-cycle blips can be rejected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) req_s_d <= 1'b0;
        else       req_s_d <= req_s;
    end

    assign req_hit = req_s & req_s_d;
`else
    assign req_hit = req_s;
`endif

    // State register: FSM state, stretch counter and sticky cause.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= HOLD;
            cnt   <= '0;
            cause <= CAUSE_POR;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cause <= cause_nx;
        end
    end

    // Next-state logic: external request always wins over software in RUN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cause_nx = cause;
        case (state)
            HOLD: begin
                if (req_hit) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RUN: begin
                if (req_hit) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    cause_nx = CAUSE_EXT;
                end else if (sw_req_valid && sw_req_ready) begin
                    state_nx = HOLD;
                    cnt_nx   = '0;
                    cause_nx = CAUSE_SW;
                end
            end
            default: begin
                state_nx = HOLD;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decode: ready comes straight from the state flop.
    always_comb begin
        sw_req_ready = (state == RUN);
    end

    // Registered outputs so the downstream buffer never sees a combinational path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_out  <= 1'b1;
            rst_done <= 1'b0;
        end else begin
            rst_out  <= (state_nx == HOLD);
            rst_done <= (state == HOLD) && (state_nx == RUN);
        end
    end

    assign rst_cause = cause;

endmodule

// File: tb/tb_rst_stretch_sync.sv
// Directed self-checking bench for rst_stretch_sync (SYNC_STAGES=3, STRETCH_CYCLES=16).
// Edge numbering: "edge k" is the k-th rising edge after the stimulus point;
// outputs are sampled 1 time unit after each rising edge.
module tb_rst_stretch_sync;

    localparam int SYNC    = 3;
    localparam int STRETCH = 16;
`ifdef RST_STRETCH_FILTER_EN
    localparam int PULSE = 2;
    localparam int LAT   = SYNC + 2;
`else
    localparam int PULSE = 1;
    localparam int LAT   = SYNC + 1;
`endif

    logic       clock;
    logic       reset;
    logic       req_async;
    logic       sw_req_valid;
    logic       sw_req_ready;
    logic       rst_out;
    logic       rst_done;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;

    rst_stretch_sync #(
        .SYNC_STAGES    (SYNC),
        .STRETCH_CYCLES (STRETCH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_async    (req_async),
        .sw_req_valid (sw_req_valid),
        .sw_req_ready (sw_req_ready),
        .rst_out      (rst_out),
        .rst_done     (rst_done),
        .rst_cause    (rst_cause)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Power-on: rst_out falls on the 16th edge after reset release.
    task automatic test_reset();
        reset = 1'b1; req_async = 1'b0; sw_req_valid = 1'b0;
        step(); step();
        checks++;
        if (rst_out !== 1'b1 || sw_req_ready !== 1'b0 || rst_done !== 1'b0 || rst_cause !== 2'd0) begin
            errors++;
            $display("FAIL reset_vals out=%b rdy=%b done=%b cause=%0d want 1 0 0 0",
                     rst_out, sw_req_ready, rst_done, rst_cause);
        end
        reset = 1'b0;
        for (int i = 1; i < STRETCH; i++) begin
            step();
            checks++;
            if (rst_out !== 1'b1 || rst_done !== 1'b0) begin
                errors++;
                $display("FAIL por_hold edge=%0d out=%b done=%b want 1 0", i, rst_out, rst_done);
            end
        end
        step();
        checks++;
        if (rst_out !== 1'b0 || rst_done !== 1'b1 || rst_cause !== 2'd0 || sw_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL por_release out=%b done=%b cause=%0d rdy=%b want 0 1 0 1",
                     rst_out, rst_done, rst_cause, sw_req_ready);
        end
        step();
        checks++;
        if (rst_done !== 1'b0 || rst_out !== 1'b0) begin
            errors++;
            $display("FAIL por_done_pulse done=%b out=%b want 0 0", rst_done, rst_out);
        end
    endtask

    // External request from RUN: HOLD after LAT edges, released LAT+STRETCH edges in.
    task automatic test_ext();
        req_async = 1'b1;
        for (int e = 1; e <= LAT + STRETCH; e++) begin
            step();
            if (e == PULSE) req_async = 1'b0;
            checks++;
            if (rst_out !== (e >= LAT && e < LAT + STRETCH)) begin
                errors++;
                $display("FAIL ext_out edge=%0d out=%b want %b", e, rst_out, (e >= LAT && e < LAT + STRETCH));
            end
        end
        checks++;
        if (rst_cause !== 2'd1 || rst_done !== 1'b1) begin
            errors++;
            $display("FAIL ext_cause cause=%0d done=%b want 1 1", rst_cause, rst_done);
        end
    endtask

`ifdef RST_STRETCH_FILTER_EN
    // A single-cycle request is rejected by the filter.
    task automatic test_filter();
        req_async = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 1) req_async = 1'b0;
            checks++;
            if (rst_out !== 1'b0 || sw_req_ready !== 1'b1) begin
                errors++;
                $display("FAIL filter_short edge=%0d out=%b rdy=%b want 0 1", e, rst_out, sw_req_ready);
            end
        end
    endtask
`endif

    // Software handshake: one-cycle latency, not accepted or queued while in HOLD.
    task automatic test_sw();
        checks++;
        if (sw_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_ready_run rdy=%b want 1", sw_req_ready);
        end
        sw_req_valid = 1'b1;
        step();
        sw_req_valid = 1'b0;
        checks++;
        if (rst_out !== 1'b1 || rst_cause !== 2'd2 || sw_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL sw_accept out=%b cause=%0d rdy=%b want 1 2 0", rst_out, rst_cause, sw_req_ready);
        end
        sw_req_valid = 1'b1;
        for (int e = 1; e < STRETCH; e++) begin
            step();
            if (e == STRETCH - 1) sw_req_valid = 1'b0;
            checks++;
            if (rst_out !== 1'b1 || sw_req_ready !== 1'b0 || rst_cause !== 2'd2) begin
                errors++;
                $display("FAIL sw_hold edge=%0d out=%b rdy=%b cause=%0d want 1 0 2",
                         e, rst_out, sw_req_ready, rst_cause);
            end
        end
        step();
        checks++;
        if (rst_out !== 1'b0 || rst_done !== 1'b1) begin
            errors++;
            $display("FAIL sw_release out=%b done=%b want 0 1", rst_out, rst_done);
        end
        step(); step();
        checks++;
        if (rst_out !== 1'b0 || sw_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_not_queued out=%b rdy=%b want 0 1", rst_out, sw_req_ready);
        end
    endtask

    // External and software request on the same RUN edge: EXT wins, single stretch.
    task automatic test_simultaneous();
        req_async = 1'b1;
        for (int e = 1; e <= LAT + STRETCH; e++) begin
            sw_req_valid = (e == LAT);
            step();
            sw_req_valid = 1'b0;
            if (e == PULSE) req_async = 1'b0;
            checks++;
            if (rst_out !== (e >= LAT && e < LAT + STRETCH)) begin
                errors++;
                $display("FAIL simul_out edge=%0d out=%b want %b", e, rst_out, (e >= LAT && e < LAT + STRETCH));
            end
        end
        checks++;
        if (rst_cause !== 2'd1) begin
            errors++;
            $display("FAIL simul_cause cause=%0d want 1", rst_cause);
        end
    endtask

    // External request mid-stretch restarts the count; cause stays SW.
    task automatic test_restart();
        sw_req_valid = 1'b1;
        step();
        sw_req_valid = 1'b0;
        for (int e = 1; e <= 7 + LAT + STRETCH; e++) begin
            if (e == 8) req_async = 1'b1;
            if (e == 8 + PULSE) req_async = 1'b0;
            step();
            checks++;
            if (rst_out !== (e < 7 + LAT + STRETCH)) begin
                errors++;
                $display("FAIL restart_out edge=%0d out=%b want %b", e, rst_out, (e < 7 + LAT + STRETCH));
            end
        end
        checks++;
        if (rst_cause !== 2'd2 || rst_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_cause cause=%0d done=%b want 2 1", rst_cause, rst_done);
        end
    endtask

    // Block reset in mid-HOLD: immediate return to POR values, full stretch after release.
    task automatic test_reset_mid();
        sw_req_valid = 1'b1;
        step();
        sw_req_valid = 1'b0;
        step(); step(); step(); step(); step();
        reset = 1'b1;
        #1;
        checks++;
        if (rst_out !== 1'b1 || rst_cause !== 2'd0 || rst_done !== 1'b0 || sw_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid out=%b cause=%0d done=%b rdy=%b want 1 0 0 0",
                     rst_out, rst_cause, rst_done, sw_req_ready);
        end
        step();
        reset = 1'b0;
        for (int e = 1; e <= STRETCH; e++) begin
            step();
            checks++;
            if (rst_out !== (e < STRETCH)) begin
                errors++;
                $display("FAIL reset_mid_stretch edge=%0d out=%b want %b", e, rst_out, (e < STRETCH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext();
`ifdef RST_STRETCH_FILTER_EN
        test_filter();
`endif
        test_sw();
        test_simultaneous();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
